// File: rtl/serial_subtractor.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands processed SLICE bits per clock,
// with the borrow/carry carried between slices in a register and valid/ready on both sides.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic             mode_q, mode_d, c_q, c_d;
  logic [KW-1:0]    k_q, k_d;
  logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [SLICE-1:0] a_sl_s, b_sl_s;
  logic [SLICE:0]   res_s;

  // Slice ALU: the extra top bit is the carry (add) or borrow (sub) out of this slice
  always_comb begin
    a_sl_s = a_q[k_q*SLICE +: SLICE];
    b_sl_s = b_q[k_q*SLICE +: SLICE];
    if (mode_q) begin
      res_s = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SLICE{1'b0}}, c_q};
    end else begin
      res_s = {1'b0, a_sl_s} - {1'b0, b_sl_s} - {{SLICE{1'b0}}, c_q};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = RUN;
        else          state_d = IDLE;
      end
      RUN: begin
        if (k_q == K_LAST) state_d = DONE;
        else               state_d = RUN;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; flags are resolved on the last slice once the full D is known
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    c_d    = c_q;
    k_d    = k_q;
    d_d    = d_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d    = A;
          b_d    = B;
          mode_d = mode;
          c_d    = Bin;
          k_d    = '0;
        end else begin
          k_d    = k_q;
        end
      end
      RUN: begin
        d_d[k_q*SLICE +: SLICE] = res_s[SLICE-1:0];
        c_d = res_s[SLICE];
        if (k_q == K_LAST) begin
          k_d    = '0;
          bout_d = res_s[SLICE];
          if (mode_q) begin
            ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (d_d[WIDTH-1] != a_q[WIDTH-1]);
          end else begin
            ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_d[WIDTH-1] != a_q[WIDTH-1]);
          end
          zero_d = (d_d == '0);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        k_d = k_q;
      end
      default: begin
        k_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      k_q     <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      k_q     <= k_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: four configurations side by side,
// directed cases on 16/4 plus random sweeps on 16/16, 32/8 and 8/1.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_s, bin_s, out_ready_s;
  logic [31:0] a_s, b_s;
  logic [3:0]  in_valid_s;
  logic [3:0]  in_ready_w, out_valid_w, bout_w, ovf_w, zero_w;
  logic [15:0] d0_w, d1_w;
  logic [31:0] d2_w;
  logic [7:0]  d3_w;

  int cfg_w [4] = '{16, 16, 32, 8};
  int cfg_n [4] = '{4, 1, 4, 8};

  typedef struct {
    logic [31:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;
  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(16), .SLICE(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]),
    .mode(mode_s), .A(a_s[15:0]), .B(b_s[15:0]), .Bin(bin_s),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_s),
    .D(d0_w), .Bout(bout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0]));

  serial_subtractor #(.WIDTH(16), .SLICE(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]),
    .mode(mode_s), .A(a_s[15:0]), .B(b_s[15:0]), .Bin(bin_s),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_s),
    .D(d1_w), .Bout(bout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1]));

  serial_subtractor #(.WIDTH(32), .SLICE(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_w[2]),
    .mode(mode_s), .A(a_s), .B(b_s), .Bin(bin_s),
    .out_valid(out_valid_w[2]), .out_ready(out_ready_s),
    .D(d2_w), .Bout(bout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2]));

  serial_subtractor #(.WIDTH(8), .SLICE(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[3]), .in_ready(in_ready_w[3]),
    .mode(mode_s), .A(a_s[7:0]), .B(b_s[7:0]), .Bin(bin_s),
    .out_valid(out_valid_w[3]), .out_ready(out_ready_s),
    .D(d3_w), .Bout(bout_w[3]), .ovf(ovf_w[3]), .zero(zero_w[3]));

  function automatic logic [31:0] get_d(input int c);
    case (c)
      0:       return {16'h0000, d0_w};
      1:       return {16'h0000, d1_w};
      2:       return d2_w;
      3:       return {24'h000000, d3_w};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation on instance c; hold > 0 keeps out_ready low that many cycles after out_valid
  task automatic do_op(input int c, input logic md, input logic [31:0] a_in,
                       input logic [31:0] b_in, input logic bi, input int hold);
    logic [63:0] mask, full;
    logic [31:0] a, b;
    exp_t e, o;
    int w, lat;
    w    = cfg_w[c];
    mask = (64'd1 << w) - 64'd1;
    a    = a_in & mask[31:0];
    b    = b_in & mask[31:0];
    if (md) full = {32'h0, a} + {32'h0, b} + {63'h0, bi};
    else    full = {32'h0, a} - {32'h0, b} - {63'h0, bi};
    e.d    = full[31:0] & mask[31:0];
    e.bout = full[w];
    if (md) e.ovf = (a[w-1] == b[w-1]) && (e.d[w-1] != a[w-1]);
    else    e.ovf = (a[w-1] != b[w-1]) && (e.d[w-1] != a[w-1]);
    e.zero = (e.d == 32'h0);
    sb_q.push_back(e);

    out_ready_s = (hold == 0);
    @(negedge clk);
    chk("in_ready_idle", in_ready_w[c], 64'd1);
    a_s = a; b_s = b; mode_s = md; bin_s = bi;
    in_valid_s[c] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[c] = 1'b0;
    a_s = $urandom; b_s = $urandom; mode_s = ~md; bin_s = ~bi;
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (lat < cfg_n[c]) chk("busy_in_ready", in_ready_w[c], 64'd0);
    end while (!out_valid_w[c] && lat < 40);
    chk("latency", 64'(lat), 64'(cfg_n[c]));
    o = sb_q.pop_front();
    chk("D", get_d(c), o.d);
    chk("Bout", bout_w[c], o.bout);
    chk("ovf", ovf_w[c], o.ovf);
    chk("zero", zero_w[c], o.zero);
    chk("done_in_ready", in_ready_w[c], 64'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid_s[c] = (i == 1);
      @(posedge clk); #1;
      in_valid_s[c] = 1'b0;
      @(negedge clk);
      chk("hold_out_valid", out_valid_w[c], 64'd1);
      chk("hold_in_ready", in_ready_w[c], 64'd0);
      chk("hold_D", get_d(c), o.d);
      chk("hold_flags", {bout_w[c], ovf_w[c], zero_w[c]}, {o.bout, o.ovf, o.zero});
    end
    out_ready_s = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_hs_out_valid", out_valid_w[c], 64'd0);
    chk("post_hs_in_ready", in_ready_w[c], 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid_s = 4'h0; out_ready_s = 1'b1;
    mode_s = 1'b0; bin_s = 1'b0; a_s = 32'h0; b_s = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("rst_in_ready", in_ready_w[c], 64'd1);
      chk("rst_out_valid", out_valid_w[c], 64'd0);
      chk("rst_D", get_d(c), 64'd0);
      chk("rst_flags", {bout_w[c], ovf_w[c], zero_w[c]}, 64'd0);
    end

    // Directed cases on the 16-bit, 4-bit-slice instance
    do_op(0, 1'b0, 32'h1234, 32'h0235, 1'b0, 0);
    do_op(0, 1'b0, 32'h0000, 32'h0001, 1'b0, 0);
    do_op(0, 1'b0, 32'h0000, 32'h0000, 1'b1, 0);
    do_op(0, 1'b0, 32'h8000, 32'h0001, 1'b0, 0);
    do_op(0, 1'b1, 32'h7FFF, 32'h0001, 1'b0, 0);
    do_op(0, 1'b1, 32'hFFFF, 32'h0001, 1'b0, 0);
    do_op(0, 1'b0, 32'h1234, 32'h1234, 1'b0, 0);
    do_op(0, 1'b1, 32'hA5A5, 32'h5A5B, 1'b1, 5);

    // Reset after slice 1 of an operation that generates a borrow chain
    @(negedge clk);
    a_s = 32'h0; b_s = 32'h1; mode_s = 1'b0; bin_s = 1'b1;
    in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("midrun_rst_in_ready", in_ready_w[0], 64'd1);
    chk("midrun_rst_out_valid", out_valid_w[0], 64'd0);
    chk("midrun_rst_D", get_d(0), 64'd0);
    chk("midrun_rst_flags", {bout_w[0], ovf_w[0], zero_w[0]}, 64'd0);
    do_op(0, 1'b0, 32'd5, 32'd3, 1'b0, 0);

    repeat (200) do_op(0, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 0);
    for (int c = 1; c < 4; c++) begin
      do_op(c, 1'b0, 32'h0, 32'h1, 1'b0, 0);
      do_op(c, 1'b1, 32'hFFFFFFFF, 32'h1, 1'b0, 2);
      repeat (2000) do_op(c, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle add/subtract unit: the successor to the fixed 4-bit ripple subtractor. A WIDTH-bit operation is processed SLICE bits per clock, with the borrow/carry held in a register between slices, so long words are handled without a full-width ripple path. Operands enter and results leave through valid/ready handshakes, so the block sits directly on the datapath between an operand-issue stage and a result consumer.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of SLICE.
- SLICE, 4: bits processed per cycle; N = WIDTH/SLICE slice cycles (N ≥ 1).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- mode  in  1  0 = subtract (A − B − Bin), 1 = add (A + B + Bin).
- A  in  WIDTH  minuend / augend.
- B  in  WIDTH  subtrahend / addend.
- Bin  in  1  borrow-in (sub) or carry-in (add).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- D  out  WIDTH  difference / sum.
- Bout  out  1  borrow-out (sub) or carry-out (add) of the MSB.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  D == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch A, B, mode and Bin into the borrow/carry register; slice index k=0; go to RUN.
- RUN: each cycle, compute slice k from bits [k*SLICE +: SLICE] and the stored borrow/carry; write the slice result into D; update the borrow/carry register; k++.
  - After slice N−1 is written, go to DONE.
  - Bout = final borrow/carry.
  - ovf, sub: A[MSB] != B[MSB] && D[MSB] != A[MSB].
  - ovf, add: A[MSB] == B[MSB] && D[MSB] != A[MSB].
  - zero = (D == 0), using the full final D.
- DONE: out_valid=1. D, Bout, ovf and zero are held stable until out_ready. On out_ready, go to IDLE.
- Arithmetic is modulo 2^WIDTH. D wraps; the wrap is reported by Bout.
- in_valid is ignored outside IDLE. A, B, mode and Bin are sampled only on the accept edge; later changes have no effect.
- Result registers (D, Bout, ovf, zero) keep their last value after the output handshake until the next operation overwrites them. Consumers must qualify them with out_valid.
- Reset (rst_n low at a rising edge), from any state including mid-RUN:
  - state → IDLE; in-flight operation discarded.
  - in_ready=1, out_valid=0.
  - D=0, Bout=0, ovf=0, zero=0; internal borrow/carry = 0, k = 0.

## Timing
- Accept edge E0; slice k is registered at edge E(k+1).
- out_valid rises after edge EN, giving a latency of N clocks from accept to result valid. WIDTH=16, SLICE=4 → 4 clocks; SLICE=WIDTH → 1 clock.
- in_ready is low from E0 until the edge at which the output handshake completes (out_valid && out_ready).
- At that edge out_valid falls and in_ready rises. The next operation can be accepted one cycle later.
- Throughput with no backpressure: one operation every N+2 cycles.
- out_valid held with out_ready low: all outputs are bit-stable every cycle.
- Outputs are registered. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- WIDTH=16, SLICE=4, sub, A=0x1234, B=0x0235, Bin=0 → D=0x0FFF, Bout=0, ovf=0, zero=0; out_valid exactly 4 clocks after accept.
- Sub wrap and borrow chain:
  - A=0x0000, B=0x0001, Bin=0 → D=0xFFFF, Bout=1, ovf=0.
  - A=0x0000, B=0x0000, Bin=1 → D=0xFFFF, Bout=1.
- Signed overflow:
  - sub A=0x8000, B=0x0001 → D=0x7FFF, ovf=1, Bout=0.
  - add A=0x7FFF, B=0x0001 → D=0x8000, ovf=1, Bout=0.
  - add A=0xFFFF, B=0x0001, Bin=0 → D=0x0000, Bout=1, zero=1, ovf=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid → D, flags and out_valid stable; in_ready=0; a new in_valid pulse is ignored.
  - Raise out_ready → in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 after slice 1 → next cycle in_ready=1, out_valid=0, D=0. A new op A=5, B=3 then yields D=2 with no stale borrow.
- Parameter sweep with 2000 random operands per configuration: (WIDTH, SLICE) = (16,16), (32,8), (8,1). Compare against a reference model of A−B−Bin / A+B+Bin; latency must equal N every time.
